ecc_correct_stage: RTL and testbench

Downstream stage of the ECC error-classification control. It consumes the received data word, the 3-bit correction select, the triple-error flag and the single-error location masks, applies the bit correction, and tags each word with a status code. It buffers the results in a small FIFO with valid/ready flow control, and keeps saturating event counters plus a sticky error interrupt for software.

---
 rtl/ecc_correct_stage.sv | 189 ++++++++++++++++++
 tb/tb_ecc_correct_stage.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ecc_correct_stage.sv
`timescale 1ns/1ps
// ecc_correct_stage
//
// Downstream stage of the ECC error-classification control. It applies the
// bit correction selected upstream and tags each word with a 2-bit status.
// Results are buffered in a small circular FIFO with valid/ready flow control.
// Saturating event counters and a sticky error interrupt are kept for software.
//
// Ports:
//   clk, rst          single clock; synchronous active-high reset
//   in_valid/in_ready upstream handshake (in_ready = FIFO not full, registered)
//   in_data           received, uncorrected word
//   in_select         0 clean, 1 single, 3 double, anything else invalid
//   in_triple         uncorrectable flag; overrides in_select
//   in_loc_a/in_loc_b one-hot error location masks (in_loc_b used for double only)
//   out_valid/out_ready downstream handshake on the FIFO head
//   out_data/out_status corrected word and status at the FIFO head
//   cnt_clear         zeroes all counters and err_irq (wins over a same-cycle event)
//   cnt_single/cnt_double/cnt_uncorr saturating event counters
//   err_irq           sticky, set by any accepted uncorrectable word
module ecc_correct_stage #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [2:0]        in_select,
    input  logic              in_triple,
    input  logic [DATA_W-1:0] in_loc_a,
    input  logic [DATA_W-1:0] in_loc_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        out_status,
    input  logic              cnt_clear,
    output logic [CNT_W-1:0]  cnt_single,
    output logic [CNT_W-1:0]  cnt_double,
    output logic [CNT_W-1:0]  cnt_uncorr,
    output logic              err_irq
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = $clog2(DEPTH) + 1;
    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);

    typedef enum logic [1:0] {
        ST_CLEAN  = 2'b00,
        ST_SINGLE = 2'b01,
        ST_DOUBLE = 2'b10,
        ST_UNCORR = 2'b11
    } status_e;

    typedef struct packed {
        status_e           status;
        logic [DATA_W-1:0] data;
    } entry_t;

    function automatic logic is_onehot(input logic [DATA_W-1:0] m);
        return (m != '0) && ((m & (m - DATA_W'(1))) == '0);
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == '1) ? c : c + CNT_W'(1);
    endfunction

    // ---------------- classification / correction ----------------
    entry_t corr;

    // NOTE: every output of a combinational block gets a default first, so no
    // path through the if/else chain can leave it unassigned and infer a latch.
    always_comb begin
        corr.data   = in_data;
        corr.status = ST_UNCORR;
        if (in_triple) begin
            corr.status = ST_UNCORR;
        end else if (in_select == 3'd0) begin
            corr.status = ST_CLEAN;
        end else if (in_select == 3'd1 && is_onehot(in_loc_a)) begin
            corr.data   = in_data ^ in_loc_a;
            corr.status = ST_SINGLE;
        end else if (in_select == 3'd3 && is_onehot(in_loc_a) && is_onehot(in_loc_b)
                     && in_loc_a != in_loc_b) begin
            corr.data   = in_data ^ (in_loc_a | in_loc_b);
            corr.status = ST_DOUBLE;
        end
    end

    // ---------------- FIFO and counters ----------------
    entry_t            mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]  occ_q, occ_d;
    entry_t            last_q, last_d;   // head value shown while the FIFO is empty
    logic [CNT_W-1:0]  cnt_single_q, cnt_single_d;
    logic [CNT_W-1:0]  cnt_double_q, cnt_double_d;
    logic [CNT_W-1:0]  cnt_uncorr_q, cnt_uncorr_d;
    logic              err_irq_q, err_irq_d;
    logic              push, pop, empty;
    entry_t            head;

    assign empty    = (occ_q == '0);
    assign in_ready = (occ_q != OCC_FULL);
    assign push     = in_valid && in_ready;
    assign pop      = out_ready && !empty;

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        occ_d        = occ_q;
        last_d       = last_q;
        cnt_single_d = cnt_single_q;
        cnt_double_d = cnt_double_q;
        cnt_uncorr_d = cnt_uncorr_q;
        err_irq_d    = err_irq_q;

        // DEPTH is a power of two, so pointers wrap by natural overflow.
        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
            last_d   = mem_q[rd_ptr_q];
        end
        case ({push, pop})
            2'b10:   occ_d = occ_q + OCC_W'(1);
            2'b01:   occ_d = occ_q - OCC_W'(1);
            default: occ_d = occ_q;
        endcase

        // Clear wins: a same-cycle event is dropped, not counted after the clear.
        if (cnt_clear) begin
            cnt_single_d = '0;
            cnt_double_d = '0;
            cnt_uncorr_d = '0;
            err_irq_d    = 1'b0;
        end else if (push) begin
            case (corr.status)
                ST_SINGLE: cnt_single_d = sat_inc(cnt_single_q);
                ST_DOUBLE: cnt_double_d = sat_inc(cnt_double_q);
                ST_UNCORR: begin
                    cnt_uncorr_d = sat_inc(cnt_uncorr_q);
                    err_irq_d    = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            occ_q        <= '0;
            last_q       <= '0;
            cnt_single_q <= '0;
            cnt_double_q <= '0;
            cnt_uncorr_q <= '0;
            err_irq_q    <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            occ_q        <= occ_d;
            last_q       <= last_d;
            cnt_single_q <= cnt_single_d;
            cnt_double_q <= cnt_double_d;
            cnt_uncorr_q <= cnt_uncorr_d;
            err_irq_q    <= err_irq_d;
        end
    end

    // NOTE: the storage array is deliberately not reset; an entry is only ever
    // read while the occupancy says it was written, and empty shows last_q.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= corr;
    end

    assign head       = empty ? last_q : mem_q[rd_ptr_q];
    assign out_valid  = !empty;
    assign out_data   = head.data;
    assign out_status = head.status;
    assign cnt_single = cnt_single_q;
    assign cnt_double = cnt_double_q;
    assign cnt_uncorr = cnt_uncorr_q;
    assign err_irq    = err_irq_q;

endmodule

// File: tb/tb_ecc_correct_stage.sv
`timescale 1ns/1ps
module tb_ecc_correct_stage;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 16;
    localparam int DEPTH  = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [2:0]        in_select;
    logic              in_triple;
    logic [DATA_W-1:0] in_loc_a;
    logic [DATA_W-1:0] in_loc_b;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [1:0]        out_status;
    logic              cnt_clear;
    logic [CNT_W-1:0]  cnt_single, cnt_double, cnt_uncorr;
    logic              err_irq;

    ecc_correct_stage #(.DATA_W(DATA_W), .CNT_W(CNT_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_select(in_select), .in_triple(in_triple),
        .in_loc_a(in_loc_a), .in_loc_b(in_loc_b),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_status(out_status),
        .cnt_clear(cnt_clear),
        .cnt_single(cnt_single), .cnt_double(cnt_double), .cnt_uncorr(cnt_uncorr),
        .err_irq(err_irq)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // FIFO contents as {status, data}; counters as plain integers.
    logic [33:0] m_q[$];
    logic [33:0] m_last;
    int unsigned m_single, m_double, m_uncorr;
    bit          m_irq;
    bit          m_accepted;
    localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

    function automatic void ref_classify(input logic [31:0] d, input logic [2:0] s,
                                         input logic t, input logic [31:0] a,
                                         input logic [31:0] b,
                                         output logic [31:0] od, output logic [1:0] os);
        od = d;
        os = 2'd3;
        if (t) os = 2'd3;
        else if (s == 0) os = 2'd0;
        else if (s == 1 && $countones(a) == 1) begin
            od = d ^ a; os = 2'd1;
        end else if (s == 3 && $countones(a) == 1 && $countones(b) == 1 && a != b) begin
            od = d ^ a ^ b; os = 2'd2;
        end
    endfunction

    function automatic int unsigned bump(input int unsigned c);
        return (c >= CNT_MAX) ? CNT_MAX : c + 1;
    endfunction

    // Runs at the clock edge on the inputs that were applied before it.
    task automatic model_update();
        logic [31:0] od;
        logic [1:0]  os;
        bit acc, rd;
        m_accepted = 0;
        if (rst) begin
            m_q.delete();
            m_last = '0;
            m_single = 0; m_double = 0; m_uncorr = 0; m_irq = 0;
            return;
        end
        acc = in_valid && (m_q.size() < DEPTH);
        rd  = out_ready && (m_q.size() > 0);
        ref_classify(in_data, in_select, in_triple, in_loc_a, in_loc_b, od, os);
        if (rd) m_last = m_q.pop_front();
        if (acc) begin
            m_q.push_back({os, od});
            m_accepted = 1;
        end
        if (cnt_clear) begin
            m_single = 0; m_double = 0; m_uncorr = 0; m_irq = 0;
        end else if (acc) begin
            case (os)
                2'd1: m_single = bump(m_single);
                2'd2: m_double = bump(m_double);
                2'd3: begin m_uncorr = bump(m_uncorr); m_irq = 1; end
                default: ;
            endcase
        end
    endtask

    task automatic compare_all();
        logic [33:0] h;
        h = (m_q.size() > 0) ? m_q[0] : m_last;
        check("out_valid",  out_valid,  m_q.size() > 0);
        check("in_ready",   in_ready,   m_q.size() < DEPTH);
        check("out_data",   out_data,   h[31:0]);
        check("out_status", out_status, h[33:32]);
        check("cnt_single", cnt_single, m_single);
        check("cnt_double", cnt_double, m_double);
        check("cnt_uncorr", cnt_uncorr, m_uncorr);
        check("err_irq",    err_irq,    m_irq);
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        compare_all();
    endtask

    task automatic drive(input bit v, input logic [31:0] d, input logic [2:0] s,
                         input bit t, input logic [31:0] a, input logic [31:0] b,
                         input bit rdy, input bit clr);
        in_valid = v; in_data = d; in_select = s; in_triple = t;
        in_loc_a = a; in_loc_b = b; out_ready = rdy; cnt_clear = clr;
    endtask

    task automatic idle(input bit rdy);
        drive(0, '0, 3'd0, 0, '0, '0, rdy, 0);
    endtask

    function automatic logic [31:0] rand_mask();
        int unsigned k;
        k = $urandom_range(0, 9);
        if (k < 7) return 32'h1 << $urandom_range(0, 31);
        if (k == 7) return '0;
        return $urandom();
    endfunction

    initial begin
        rst = 1'b1;
        idle(0);
        m_last = '0;
        step();
        step();
        rst = 1'b0;
        step();
        check("reset_out_data", out_data, 32'h0);

        // Clean path
        drive(1, 32'hA5A5A5A5, 3'd0, 0, '0, '0, 0, 0);
        step();
        idle(0);
        check("clean_data", out_data, 32'hA5A5A5A5);
        check("clean_status", out_status, 2'b00);
        drive(0, '0, 3'd0, 0, '0, '0, 1, 0);
        step();

        // Single correction, then a multi-hot mask
        drive(1, 32'h10, 3'd1, 0, 32'h10, 32'hDEAD, 1, 0);
        step();
        check("single_data", out_data, 32'h0);
        check("single_status", out_status, 2'b01);
        drive(1, 32'h10, 3'd1, 0, 32'h11, '0, 1, 0);
        step();
        check("multihot_data", out_data, 32'h10);
        check("multihot_status", out_status, 2'b11);

        // Double, then triple overriding select=1
        drive(1, 32'hFFFFFFFF, 3'd3, 0, 32'h1, 32'h80000000, 1, 0);
        step();
        check("double_data", out_data, 32'h7FFFFFFE);
        check("double_status", out_status, 2'b10);
        drive(1, 32'h12345678, 3'd1, 1, 32'h8, '0, 1, 0);
        step();
        check("triple_data", out_data, 32'h12345678);
        check("triple_status", out_status, 2'b11);
        idle(1);
        step();
        step();

        // Backpressure: three offers into a two-deep FIFO
        for (int i = 0; i < 3; i++) begin
            drive(1, 32'h100 + i, 3'd0, 0, '0, '0, 0, 0);
            step();
        end
        check("bp_full_in_ready", in_ready, 1'b0);
        check("bp_head", out_data, 32'h100);
        begin
            bit got3 = 0;
            for (int i = 0; i < 6 && !got3; i++) begin
                drive(1, 32'h102, 3'd0, 0, '0, '0, 1, 0);
                step();
                got3 = m_accepted;
            end
            check("bp_third_accepted", got3, 1'b1);
        end
        idle(1);
        for (int i = 0; i < 4; i++) step();

        // Clear together with an uncorrectable accept
        drive(1, 32'hBEEF, 3'd5, 0, '0, '0, 1, 1);
        step();
        check("clr_uncorr", cnt_uncorr, 0);
        check("clr_irq", err_irq, 1'b0);
        idle(1);
        step();

        // Saturation of cnt_single
        for (int i = 0; i < (1 << CNT_W) + 3; i++) begin
            drive(1, $urandom(), 3'd1, 0, 32'h1 << (i % 32), '0, 1, 0);
            step();
        end
        check("sat_single", cnt_single, 16'hFFFF);
        idle(1);
        step();

        // Reset with two buffered words
        drive(1, 32'hAAAA0001, 3'd0, 0, '0, '0, 0, 0);
        step();
        drive(1, 32'hAAAA0002, 3'd1, 0, 32'h2, '0, 0, 0);
        step();
        idle(0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_cnt_single", cnt_single, 0);
        idle(1);
        for (int i = 0; i < 3; i++) step();

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            logic [2:0] s;
            s = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7))
                                            : (($urandom_range(0, 2) == 0) ? 3'd0
                                              : (($urandom_range(0, 1) == 0) ? 3'd1 : 3'd3));
            drive($urandom_range(0, 3) != 0, $urandom(), s,
                  $urandom_range(0, 9) == 0, rand_mask(),
                  ($urandom_range(0, 7) == 0) ? in_loc_a : rand_mask(),
                  $urandom_range(0, 4) < 3, $urandom_range(0, 49) == 0);
            rst = ($urandom_range(0, 299) == 0);
            step();
        end
        rst = 1'b0;
        idle(1);
        for (int i = 0; i < 4; i++) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
